// File: rtl/stream_demux_1_to_n.sv
// Registered 1-to-N stream demultiplexer with per-channel holding slots,
// broadcast mode and sticky out-of-range select detection with a drop counter.
module stream_demux_1_to_n #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   select,
    input  logic               broadcast,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    input  logic               err_clr,
    output logic               err_sel,
    output logic [7:0]         drop_count
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam int              SEL_SPAN = 1 << SEL_W;
    localparam logic [SEL_W:0]  N_LIMIT  = (SEL_W + 1)'(N);
    localparam logic [7:0]      CNT_MAX  = 8'hFF;

    logic [N-1:0]        slot_free;
    logic [N-1:0]        load;
    logic [SEL_SPAN-1:0] free_ext;
    logic                sel_in_range;
    logic                accept;
    logic                drop;

    logic                err_sel_reg;
    logic                err_sel_next;
    logic [7:0]          drop_count_reg;
    logic [7:0]          drop_count_next;

    assign slot_free    = ~out_valid | out_ready;
    // Zero-extend so any select value indexes safely when N < 2**SEL_W.
    assign free_ext     = SEL_SPAN'(slot_free);
    assign sel_in_range = ({1'b0, select} < N_LIMIT);

    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            in_ready = 1'b0;
        end else if (broadcast) begin
            in_ready = &slot_free;
        end else if (sel_in_range) begin
            in_ready = free_ext[select];
        end else begin
            in_ready = 1'b1;
        end
    end

    assign accept = in_valid & in_ready;
    assign drop   = accept & ~broadcast & ~sel_in_range;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            slot_state_t      state_reg;
            slot_state_t      state_next;
            logic [WIDTH-1:0] data_reg;
            logic [WIDTH-1:0] data_next;

            assign load[gi] = accept &
                              (broadcast | (sel_in_range & (select == SEL_W'(gi))));

            always_comb begin
                state_next = state_reg;
                data_next  = data_reg;
                if (load[gi]) begin
                    state_next = SLOT_FULL;
                    data_next  = in_data;
                end else if ((state_reg == SLOT_FULL) && out_ready[gi]) begin
                    // Drained slots return to zero so idle outputs never show stale data.
                    state_next = SLOT_EMPTY;
                    data_next  = '0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= SLOT_EMPTY;
                    data_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    data_reg  <= data_next;
                end
            end

            assign out_valid[gi]                 = (state_reg == SLOT_FULL);
            assign out_data[gi*WIDTH +: WIDTH]   = data_reg;
        end
    endgenerate

    // A drop arriving with err_clr counts as the first event after the clear.
    always_comb begin
        err_sel_next    = err_sel_reg;
        drop_count_next = drop_count_reg;
        if (drop) begin
            err_sel_next = 1'b1;
            if (err_clr) begin
                drop_count_next = 8'd1;
            end else if (drop_count_reg != CNT_MAX) begin
                drop_count_next = drop_count_reg + 8'd1;
            end
        end else if (err_clr) begin
            err_sel_next    = 1'b0;
            drop_count_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sel_reg    <= 1'b0;
            drop_count_reg <= 8'd0;
        end else begin
            err_sel_reg    <= err_sel_next;
            drop_count_reg <= drop_count_next;
        end
    end

    assign err_sel    = err_sel_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_stream_demux_1_to_n.sv
// Directed bench: a 4-channel instance driven from a vector table and a
// 3-channel instance exercising out-of-range selects and the drop counter.
module tb_stream_demux_1_to_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=4
    logic        a_rst;
    logic [7:0]  a_in_data;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [1:0]  a_select;
    logic        a_broadcast;
    logic [31:0] a_out_data;
    logic [3:0]  a_out_valid;
    logic [3:0]  a_out_ready;
    logic        a_err_clr;
    logic        a_err_sel;
    logic [7:0]  a_drop_count;

    // Instance B: N=3, so select=3 is out of range
    logic        b_rst;
    logic [7:0]  b_in_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [1:0]  b_select;
    logic        b_broadcast;
    logic [23:0] b_out_data;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic        b_err_clr;
    logic        b_err_sel;
    logic [7:0]  b_drop_count;

    stream_demux_1_to_n #(.WIDTH(8), .N(4), .SEL_W(2)) dut_a (
        .clk(clk), .rst(a_rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .select(a_select), .broadcast(a_broadcast),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .err_clr(a_err_clr), .err_sel(a_err_sel), .drop_count(a_drop_count)
    );

    stream_demux_1_to_n #(.WIDTH(8), .N(3), .SEL_W(2)) dut_b (
        .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .select(b_select), .broadcast(b_broadcast),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .err_clr(b_err_clr), .err_sel(b_err_sel), .drop_count(b_drop_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        valid;
        logic [7:0]  data;
        logic [1:0]  sel;
        logic        bcast;
        logic [3:0]  oready;
        logic        exp_ready;
        logic [3:0]  exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                                input logic [1:0] s, input logic b, input logic [3:0] o,
                                input logic er, input logic [3:0] ev, input logic [31:0] ed);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d; t.sel = s; t.bcast = b; t.oready = o;
        t.exp_ready = er; t.exp_valid = ev; t.exp_data = ed;
        return t;
    endfunction

    localparam int NV = 22;
    vec_t vecs[NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int model_cnt;

        //           rst v  data   sel   bc  oready   rdy  valid    data
        vecs[0]  = mk(1, 0, 8'h00, 2'd0, 0, 4'b1111, 0, 4'b0000, 32'h00000000);
        vecs[1]  = mk(1, 1, 8'hA5, 2'd0, 0, 4'b1111, 0, 4'b0000, 32'h00000000);
        // routed sweep
        vecs[2]  = mk(0, 1, 8'hA5, 2'd0, 0, 4'b1111, 1, 4'b0001, 32'h000000A5);
        vecs[3]  = mk(0, 1, 8'hA5, 2'd1, 0, 4'b1111, 1, 4'b0010, 32'h0000A500);
        vecs[4]  = mk(0, 1, 8'hA5, 2'd2, 0, 4'b1111, 1, 4'b0100, 32'h00A50000);
        vecs[5]  = mk(0, 1, 8'hA5, 2'd3, 0, 4'b1111, 1, 4'b1000, 32'hA5000000);
        vecs[6]  = mk(0, 0, 8'h00, 2'd3, 0, 4'b1111, 1, 4'b0000, 32'h00000000);
        // backpressure on channel 2
        vecs[7]  = mk(0, 1, 8'h11, 2'd2, 0, 4'b1011, 1, 4'b0100, 32'h00110000);
        vecs[8]  = mk(0, 1, 8'h22, 2'd2, 0, 4'b1011, 0, 4'b0100, 32'h00110000);
        vecs[9]  = mk(0, 1, 8'h22, 2'd2, 0, 4'b1111, 1, 4'b0100, 32'h00220000);
        vecs[10] = mk(0, 0, 8'h00, 2'd2, 0, 4'b1111, 1, 4'b0000, 32'h00000000);
        // broadcast blocked by stalled channel 1, then released
        vecs[11] = mk(0, 1, 8'h77, 2'd1, 0, 4'b1101, 1, 4'b0010, 32'h00007700);
        vecs[12] = mk(0, 1, 8'h3C, 2'd1, 1, 4'b1101, 0, 4'b0010, 32'h00007700);
        vecs[13] = mk(0, 1, 8'h3C, 2'd1, 1, 4'b1111, 1, 4'b1111, 32'h3C3C3C3C);
        vecs[14] = mk(0, 1, 8'h5A, 2'd1, 1, 4'b1111, 1, 4'b1111, 32'h5A5A5A5A);
        vecs[15] = mk(0, 0, 8'h00, 2'd1, 0, 4'b1111, 1, 4'b0000, 32'h00000000);
        // reset mid-operation with slots 0 and 3 stalled
        vecs[16] = mk(0, 1, 8'h81, 2'd0, 0, 4'b0000, 1, 4'b0001, 32'h00000081);
        vecs[17] = mk(0, 1, 8'h93, 2'd3, 0, 4'b0000, 1, 4'b1001, 32'h93000081);
        vecs[18] = mk(0, 1, 8'h44, 2'd0, 0, 4'b0000, 0, 4'b1001, 32'h93000081);
        vecs[19] = mk(1, 1, 8'h44, 2'd1, 0, 4'b0000, 0, 4'b0000, 32'h00000000);
        vecs[20] = mk(0, 1, 8'h55, 2'd1, 0, 4'b0000, 1, 4'b0010, 32'h00005500);
        vecs[21] = mk(0, 0, 8'h00, 2'd1, 0, 4'b0010, 1, 4'b0000, 32'h00000000);

        a_err_clr = 1'b0;
        b_rst = 1'b1; b_in_data = 8'h00; b_in_valid = 1'b0; b_select = 2'd0;
        b_broadcast = 1'b0; b_out_ready = 3'b111; b_err_clr = 1'b0;

        for (int i = 0; i < NV; i++) begin
            a_rst = vecs[i].rst; a_in_valid = vecs[i].valid; a_in_data = vecs[i].data;
            a_select = vecs[i].sel; a_broadcast = vecs[i].bcast; a_out_ready = vecs[i].oready;
            #1;
            check($sformatf("vec%0d in_ready", i), 64'(a_in_ready), 64'(vecs[i].exp_ready));
            tick();
            check($sformatf("vec%0d out_valid", i), 64'(a_out_valid), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d out_data", i), 64'(a_out_data), 64'(vecs[i].exp_data));
            $display("vec %0d rst=%0b v=%0b sel=%0d bc=%0b data=%h -> valid=%b out=%h",
                     i, vecs[i].rst, vecs[i].valid, vecs[i].sel, vecs[i].bcast,
                     vecs[i].data, a_out_valid, a_out_data);
        end
        check("a err_sel idle", 64'(a_err_sel), 64'd0);
        check("a drop_count idle", 64'(a_drop_count), 64'd0);

        // Instance B: reset release
        a_in_valid = 1'b0;
        tick();
        b_rst = 1'b0;
        tick();
        check("b reset err_sel", 64'(b_err_sel), 64'd0);
        check("b reset drop_count", 64'(b_drop_count), 64'd0);
        check("b reset out_valid", 64'(b_out_valid), 64'd0);

        // 300 out-of-range words: all sunk, counter saturates
        model_cnt = 0;
        b_in_valid = 1'b1; b_select = 2'd3; b_in_data = 8'hE7;
        for (int k = 0; k < 300; k++) begin
            #1;
            check($sformatf("drop%0d in_ready", k), 64'(b_in_ready), 64'd1);
            tick();
            model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
            check($sformatf("drop%0d out_valid", k), 64'(b_out_valid), 64'd0);
            check($sformatf("drop%0d drop_count", k), 64'(b_drop_count), 64'(model_cnt));
        end
        $display("drop burst: err_sel=%0b drop_count=%0d", b_err_sel, b_drop_count);
        check("sat err_sel", 64'(b_err_sel), 64'd1);
        check("sat drop_count", 64'(b_drop_count), 64'd255);

        // err_clr alone
        b_in_valid = 1'b0; b_err_clr = 1'b1;
        tick();
        b_err_clr = 1'b0;
        $display("err_clr: err_sel=%0b drop_count=%0d", b_err_sel, b_drop_count);
        check("clr err_sel", 64'(b_err_sel), 64'd0);
        check("clr drop_count", 64'(b_drop_count), 64'd0);

        // seven drops, then clear colliding with a drop
        b_in_valid = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        check("seven drops", 64'(b_drop_count), 64'd7);
        b_err_clr = 1'b1;
        tick();
        b_err_clr = 1'b0; b_in_valid = 1'b0;
        $display("collision: err_sel=%0b drop_count=%0d", b_err_sel, b_drop_count);
        check("collision err_sel", 64'(b_err_sel), 64'd1);
        check("collision drop_count", 64'(b_drop_count), 64'd1);

        // broadcast with select=3 is not a drop
        b_in_valid = 1'b1; b_broadcast = 1'b1; b_in_data = 8'h6D;
        #1;
        check("b bcast in_ready", 64'(b_in_ready), 64'd1);
        tick();
        b_broadcast = 1'b0; b_in_valid = 1'b0;
        $display("b broadcast: valid=%b data=%h cnt=%0d", b_out_valid, b_out_data, b_drop_count);
        check("b bcast out_valid", 64'(b_out_valid), 64'b111);
        check("b bcast out_data", 64'(b_out_data), 64'h6D6D6D);
        check("b bcast drop_count", 64'(b_drop_count), 64'd1);

        // routed to the top in-range channel
        b_in_valid = 1'b1; b_select = 2'd2; b_in_data = 8'hC4;
        tick();
        b_in_valid = 1'b0;
        $display("b route sel=2: valid=%b data=%h", b_out_valid, b_out_data);
        check("b route out_valid", 64'(b_out_valid), 64'b100);
        check("b route out_data", 64'(b_out_data), 64'hC40000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
